// File: rtl/mdu_core.sv
// Multiply/divide unit holding the architectural HI/LO pair.
// Results are computed from captured operands and committed after a fixed busy window.
module mdu_core #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } opnd_t;

    state_t      state, state_nx;
    opnd_t       cap;
    logic [4:0]  cnt, term;
    logic        launch, is_long, done;

    assign busy    = (state == RUN);
    assign launch  = start && !req && !busy && (mdu_op inside {[3'd1:3'd6]});
    assign is_long = mdu_op inside {[3'd1:3'd4]};
    assign term    = (cap.op == OP_MULT || cap.op == OP_MULTU) ? MULT_CYCLES[4:0] : DIV_CYCLES[4:0];
    assign done    = (state == RUN) && (cnt == term);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch && is_long) state_nx = RUN;
            RUN:     if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // cnt counts busy cycles 1..term; commit happens on the edge where cnt==term
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap <= '0;
            cnt <= '0;
        end else if (launch && is_long) begin
            cap <= '{op: mdu_op, a: A, b: B};
            cnt <= 5'd1;
        end else if (done) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
        end
    end

    logic [63:0] prod_s, prod_u;
    logic [31:0] b_nz, a_mag, b_mag, q_m, r_m, q_s, r_s, q_u, r_u;

    // Signed divide runs on magnitudes so MIN/-1 simply wraps to MIN with no trap
    always_comb begin
        prod_s = {{32{cap.a[31]}}, cap.a} * {{32{cap.b[31]}}, cap.b};
        prod_u = {32'd0, cap.a} * {32'd0, cap.b};
        b_nz   = (cap.b == 32'd0) ? 32'd1 : cap.b;
        q_u    = cap.a / b_nz;
        r_u    = cap.a % b_nz;
        a_mag  = cap.a[31] ? -cap.a : cap.a;
        b_mag  = cap.b[31] ? -cap.b : b_nz;
        q_m    = a_mag / b_mag;
        r_m    = a_mag % b_mag;
        q_s    = (cap.a[31] ^ cap.b[31]) ? -q_m : q_m;
        r_s    = cap.a[31] ? -r_m : r_m;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else if (done) begin
            case (cap.op)
                OP_MULT:  {HI, LO} <= prod_s;
                OP_MULTU: {HI, LO} <= prod_u;
                OP_DIV:   if (cap.b != 32'd0) begin HI <= r_s; LO <= q_s; end
                OP_DIVU:  if (cap.b != 32'd0) begin HI <= r_u; LO <= q_u; end
                default: ;
            endcase
        end else if (launch && mdu_op == OP_MTHI) begin
            HI <= A;
        end else if (launch && mdu_op == OP_MTLO) begin
            LO <= A;
        end
    end
endmodule
